// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32I load/store initiator toward the data memory
//
// Accepts one load/store request at a time, drives a word-aligned memory
// access, waits for mem_ack (bounded by TIMEOUT_CYCLES) and returns the
// extended load data with a one-cycle resp_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests are rejected with resp_err
//   undefined - offset bits below the access size are forced to zero
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake from the core
//   req_we, req_funct3            store flag and RV32I funct3
//   req_addr, req_wdata           byte address and store data
//   resp_valid, resp_rdata        one-cycle response pulse, extended load data
//   resp_err                      misaligned / illegal funct3 / timeout
//   mem_A, mem_WD, mem_WE, mem_BE word address, lane data, write enable, byte enables
//   mem_req, mem_ack, mem_RD      access in progress, completion, read data
module lsu_mem_master #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_RDATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    output logic [3:0]  mem_BE,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    // Request decode
    logic        f3_bad;
    logic        req_illegal;
    logic [1:0]  off_eff;
    logic [3:0]  be_next;
    logic [31:0] wd_next;

    // funct3[1:0] encodes size (00 byte, 01 half, 10 word); 1xx is only legal as LBU/LHU loads
    assign f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_funct3[2] && req_we);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_illegal = f3_bad || misalign;
    assign off_eff     = req_addr[1:0];
`else
    assign req_illegal = f3_bad;
    always_comb begin
        off_eff = 2'b00;
        case (req_funct3[1:0])
            2'b00:   off_eff = req_addr[1:0];
            2'b01:   off_eff = req_addr[1:0] & 2'b10;
            default: off_eff = 2'b00;
        endcase
    end
`endif

    always_comb begin
        be_next = 4'b1111;
        wd_next = req_wdata;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_next = 4'b0001 << off_eff;
                    wd_next = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_next = 4'b0011 << off_eff;
                    wd_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_next = 4'b1111;
                    wd_next = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the captured offset and funct3
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign byte_sel = mem_RD[{off_q, 3'b000} +: 8];
    assign half_sel = mem_RD[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mem_RD;
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_RD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= RESET_RDATA;
            mem_req    <= 1'b0;
            mem_WE     <= 1'b0;
            mem_BE     <= 4'b0000;
            mem_A      <= 32'h0;
            mem_WD     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= off_eff;
                        req_ready <= 1'b0;
                        if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state   <= ACCESS;
                            cnt     <= 8'd0;
                            mem_req <= 1'b1;
                            mem_A   <= {req_addr[31:2], 2'b00};
                            mem_WD  <= wd_next;
                            mem_WE  <= req_we;
                            mem_BE  <= be_next;
                        end
                    end
                end
                ACCESS: begin
                    // A late ack on the final counted cycle still completes normally
                    if (mem_ack) begin
                        if (!we_q) begin
                            resp_rdata <= load_data;
                        end
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        mem_req    <= 1'b0;
                        mem_WE     <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        mem_req    <= 1'b0;
                        mem_WE     <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

    localparam int          TMO  = 16;
    localparam logic [31:0] RRST = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [3:0]  mem_BE;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_RD;

    int checks = 0;
    int errors = 0;

    lsu_mem_master #(.TIMEOUT_CYCLES(TMO), .RESET_RDATA(RRST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_BE(mem_BE),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one accepting edge, then withdraws it
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b1; mem_RD = 32'h0;

        // Reset with mem_ack high
        tick(); tick();
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, RRST);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_mem_WE", {31'h0, mem_WE}, 32'd0);
        chk("rst_mem_BE", {28'h0, mem_BE}, 32'd0);
        chk("rst_mem_A", mem_A, 32'h0);
        chk("rst_mem_WD", mem_WD, 32'h0);
        rst_n = 1'b1; mem_ack = 1'b0;
        tick();

        // SB at 0x1003
        do_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        chk("sb_mem_req", {31'h0, mem_req}, 32'd1);
        chk("sb_req_ready", {31'h0, req_ready}, 32'd0);
        chk("sb_mem_A", mem_A, 32'h0000_1000);
        chk("sb_mem_BE", {28'h0, mem_BE}, 32'h8);
        chk("sb_mem_WD", mem_WD, 32'hA5A5_A5A5);
        chk("sb_mem_WE", {31'h0, mem_WE}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sb_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("sb_resp_err", {31'h0, resp_err}, 32'd0);
        chk("sb_mem_req_drop", {31'h0, mem_req}, 32'd0);
        chk("sb_mem_WE_drop", {31'h0, mem_WE}, 32'd0);
        chk("sb_rdata_kept", resp_rdata, RRST);
        tick();
        chk("sb_pulse_end", {31'h0, resp_valid}, 32'd0);
        chk("sb_ready_back", {31'h0, req_ready}, 32'd1);

        // LB / LBU at 0x2002
        mem_RD = 32'h0080_0000;
        do_req(1'b0, 3'b000, 32'h0000_2002, 32'h0);
        chk("lb_mem_BE", {28'h0, mem_BE}, 32'hF);
        chk("lb_mem_A", mem_A, 32'h0000_2000);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("lb_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        tick();
        do_req(1'b0, 3'b100, 32'h0000_2002, 32'h0);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("lbu_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        tick();

        // LH at 0x3002, ack after 3 wait cycles
        mem_RD = 32'h8001_1234;
        do_req(1'b0, 3'b001, 32'h0000_3002, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("lh_mem_req_held", {31'h0, mem_req}, 32'd1);
            chk("lh_mem_A_held", mem_A, 32'h0000_3000);
            chk("lh_resp_idle", {31'h0, resp_valid}, 32'd0);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("lh_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("lh_resp_err", {31'h0, resp_err}, 32'd0);
        chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
        tick();

        // SH at 0x0102
        do_req(1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_BEEF);
        chk("sh_mem_BE", {28'h0, mem_BE}, 32'hC);
        chk("sh_mem_WD", mem_WD, 32'hBEEF_BEEF);
        chk("sh_mem_A", mem_A, 32'h0000_0100);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("sh_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("sh_rdata_kept", resp_rdata, 32'hFFFF_8001);
        tick();

        // Illegal funct3 011
        do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0);
        chk("f3_011_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("f3_011_resp_err", {31'h0, resp_err}, 32'd1);
        chk("f3_011_mem_req", {31'h0, mem_req}, 32'd0);
        tick();
        chk("f3_011_ready", {31'h0, req_ready}, 32'd1);

        // Store with an unsigned-load funct3 is illegal
        do_req(1'b1, 3'b100, 32'h0000_0020, 32'h0);
        chk("sbu_resp_err", {31'h0, resp_err}, 32'd1);
        chk("sbu_mem_req", {31'h0, mem_req}, 32'd0);
        tick();

        // LW at 0x4001
        mem_RD = 32'hCAFE_F00D;
        do_req(1'b0, 3'b010, 32'h0000_4001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("lw_mis_resp_err", {31'h0, resp_err}, 32'd1);
        chk("lw_mis_mem_req", {31'h0, mem_req}, 32'd0);
        tick();
        chk("lw_mis_mem_req_after", {31'h0, mem_req}, 32'd0);
`else
        chk("lw_mis_mem_req", {31'h0, mem_req}, 32'd1);
        chk("lw_mis_mem_A", mem_A, 32'h0000_4000);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("lw_mis_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("lw_mis_resp_err", {31'h0, resp_err}, 32'd0);
        chk("lw_mis_rdata", resp_rdata, 32'hCAFE_F00D);
        tick();
`endif

        // Timeout on SW, then a normal LW
        do_req(1'b1, 3'b010, 32'h0000_5000, 32'h1122_3344);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_access_cycles", n, TMO);
        chk("tmo_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("tmo_resp_err", {31'h0, resp_err}, 32'd1);
        chk("tmo_mem_WE", {31'h0, mem_WE}, 32'd0);
        tick();
        mem_RD = 32'h0BAD_F00D;
        do_req(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("post_tmo_resp_valid", {31'h0, resp_valid}, 32'd1);
        chk("post_tmo_resp_err", {31'h0, resp_err}, 32'd0);
        chk("post_tmo_rdata", resp_rdata, 32'h0BAD_F00D);
        tick();

        // mem_ack while idle is ignored
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("idle_ack_resp", {31'h0, resp_valid}, 32'd0);
        chk("idle_ack_ready", {31'h0, req_ready}, 32'd1);

        // Reset mid-access
        do_req(1'b0, 3'b010, 32'h0000_7000, 32'h0);
        chk("midrst_mem_req_before", {31'h0, mem_req}, 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("midrst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("midrst_ready", {31'h0, req_ready}, 32'd1);
        chk("midrst_rdata", resp_rdata, RRST);
        tick();
        chk("midrst_no_resp", {31'h0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
